// File: rtl/tt_sweep_checker_pkg.sv
// Shared types and constants for the truth-table sweep checker.
package tt_sweep_checker_pkg;
  localparam int ROW_W    = 4;
  localparam int TT_WIDTH = 16;
  localparam logic [TT_WIDTH-1:0] DEFAULT_EXPECTED = 16'hE93A;
  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(TT_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  // Row r lives at table bit 15-r, which for a 4-bit row is just ~r.
  function automatic logic [ROW_W-1:0] tt_idx(input logic [ROW_W-1:0] row);
    return ~row;
  endfunction
endpackage

// File: rtl/tt_sweep_checker_sync2.sv
// Two-flop synchronizer bringing the circuit-under-test output into clk.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 16 input rows into an external 4-input circuit, samples its
// synchronized output per row, and compares against an expected truth table.
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter logic [TT_WIDTH-1:0] EXPECTED = DEFAULT_EXPECTED,
  parameter int                  SETTLE   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                cut_out,
  output logic                in1,
  output logic                in2,
  output logic                in3,
  output logic                in4,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [TT_WIDTH-1:0] observed,
  output logic [4:0]          fail_count,
  output logic [ROW_W-1:0]    first_fail
);
  localparam logic [7:0] SETTLE_LD = 8'(SETTLE);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] drv;
  logic [7:0]       cnt;
  logic             cut_sync;
  logic             mismatch;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cut_out),
    .q     (cut_sync)
  );

  // Drives are a register so they cannot glitch between rows.
  assign {in1, in2, in3, in4} = drv;
  assign mismatch = cut_sync != EXPECTED[tt_idx(row)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      row        <= '0;
      cnt        <= '0;
      drv        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      observed   <= '0;
      fail_count <= '0;
      first_fail <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Partial observed/fail_count are kept for post-mortem inspection.
        state <= ST_IDLE;
        row   <= '0;
        cnt   <= '0;
        drv   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              observed   <= '0;
              fail_count <= '0;
              first_fail <= '0;
              pass       <= 1'b0;
              row        <= '0;
              drv        <= '0;
              cnt        <= SETTLE_LD;
              busy       <= 1'b1;
              state      <= ST_SETTLE;
            end
          end
          ST_SETTLE: begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) state <= ST_SAMPLE;
          end
          ST_SAMPLE: begin
            observed[tt_idx(row)] <= cut_sync;
            if (mismatch) begin
              fail_count <= fail_count + 5'd1;
              if (fail_count == 5'd0) first_fail <= row;
            end
            if (row == ROW_LAST) begin
              drv   <= '0;
              state <= ST_DONE;
            end else begin
              row   <= row + 1'b1;
              drv   <= row + 1'b1;
              cnt   <= SETTLE_LD;
              state <= ST_SETTLE;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            pass  <= (fail_count == 5'd0);
            busy  <= 1'b0;
            row   <= '0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tt_sweep_checker.sv
// Scoreboard bench: predicted sweep results are queued at start and checked at done.
module tb_tt_sweep_checker;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cut_out;
  logic        in1, in2, in3, in4;
  logic        busy, done, pass;
  logic [15:0] observed;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail;

  int checks = 0;
  int failures = 0;
  int mode = 0;  // 0: gate model, 1: tied 0, 2: tied 1

  localparam logic [15:0] EXP_TT = 16'hE93A;

  typedef struct {
    logic [15:0] obs;
    logic [4:0]  fc;
    logic [3:0]  ff;
    logic        ps;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  tt_sweep_checker #(.EXPECTED(16'hE93A), .SETTLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .cut_out    (cut_out),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .in4        (in4),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .observed   (observed),
    .fail_count (fail_count),
    .first_fail (first_fail)
  );

  // NOR/NOT realisation of E93A: inverters, five NOR maxterm covers, final NOR.
  function automatic logic gate_fn(input logic [3:0] r);
    logic a, b, c, d, na, nb, nc, nd, c1, c2, c3, c4, c5;
    {a, b, c, d} = r;
    na = ~a; nb = ~b; nc = ~c; nd = ~d;
    c1 = ~(a | b | nc | nd);
    c2 = ~(a | nb | nc | d);
    c3 = ~(na | b | c);
    c4 = ~(nb | c | nd);
    c5 = ~(na | nb | nd);
    return ~(c1 | c2 | c3 | c4 | c5);
  endfunction

  function automatic logic cut_fn(input int m, input logic [3:0] r);
    if (m == 1) return 1'b0;
    if (m == 2) return 1'b1;
    return gate_fn(r);
  endfunction

  assign cut_out = cut_fn(mode, {in1, in2, in3, in4});

  function automatic exp_t predict(input int m);
    exp_t e;
    logic bit_v;
    e.obs = '0; e.fc = '0; e.ff = '0;
    for (int r = 0; r < 16; r++) begin
      bit_v = cut_fn(m, 4'(r));
      e.obs[15-r] = bit_v;
      if (bit_v != EXP_TT[15-r]) begin
        if (e.fc == 0) e.ff = 4'(r);
        e.fc = e.fc + 5'd1;
      end
    end
    e.ps = (e.fc == 0);
    return e;
  endfunction

  task automatic tb_chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    tb_chk({tag, "_busy"}, 32'(busy), 0);
    tb_chk({tag, "_done"}, 32'(done), 0);
    tb_chk({tag, "_pass"}, 32'(pass), 0);
    tb_chk({tag, "_obs"}, 32'(observed), 0);
    tb_chk({tag, "_fc"}, 32'(fail_count), 0);
    tb_chk({tag, "_ff"}, 32'(first_fail), 0);
    tb_chk({tag, "_drv"}, 32'({in1, in2, in3, in4}), 0);
  endtask

  // k counts rising edges after the start-accept edge; sampling is at the following negedge.
  task automatic run_sweep(input int m, input bit repulse);
    exp_t got;
    logic [3:0] drv[80];
    int k, bad, busy_bad;
    mode = m;
    sb.push_back(predict(m));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    k = 0; busy_bad = 0;
    while (1) begin
      if (k < 80) drv[k] = {in1, in2, in3, in4};
      if (done) break;
      if (k < 81 && !busy) busy_bad++;
      if (k >= 200) break;
      start = repulse && (k == 4 || k == 39);
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    tb_chk("done_cycle", k, 81);
    tb_chk("busy_during", busy_bad, 0);
    bad = -1;
    for (int j = 79; j >= 0; j--)
      if (drv[j] !== 4'(j / 5)) bad = j;
    tb_chk("drv_stable", bad, -1);
    if (sb.size() == 0) begin
      tb_chk("sb_underflow", 1, 0);
    end else begin
      got = sb.pop_front();
      tb_chk("observed", 32'(observed), 32'(got.obs));
      tb_chk("fail_count", 32'(fail_count), 32'(got.fc));
      tb_chk("first_fail", 32'(first_fail), 32'(got.ff));
      tb_chk("pass", 32'(pass), 32'(got.ps));
      repeat (3) @(negedge clk);
      tb_chk("done_pulse", 32'(done), 0);
      tb_chk("pass_held", 32'(pass), 32'(got.ps));
      tb_chk("idle_drv", 32'({in1, in2, in3, in4}), 0);
    end
  endtask

  initial begin
    int done_seen;
    @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 1'b0);
    run_sweep(1, 1'b0);
    run_sweep(2, 1'b0);

    // Abort in row 7: abort seen at edge 38, rows 0..6 already sampled.
    mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (37) @(negedge clk);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    tb_chk("abort_busy", 32'(busy), 0);
    tb_chk("abort_drv", 32'({in1, in2, in3, in4}), 0);
    tb_chk("abort_partial", 32'(observed[15:9]), 32'(EXP_TT[15:9]));
    done_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    tb_chk("abort_nodone", done_seen, 0);
    run_sweep(0, 1'b0);

    // Asynchronous reset during row 10.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (52) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk) rst_n = 1'b1;
    run_sweep(0, 1'b0);

    // Start re-pulses mid-sweep must be ignored.
    run_sweep(0, 1'b1);

    // abort and start together in IDLE: nothing starts.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    tb_chk("abort_start_busy", 32'(busy), 0);
    repeat (10) @(negedge clk);
    tb_chk("abort_start_idle", 32'({busy, in1, in2, in3, in4}), 0);

    tb_chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
